// File: rtl/mem_access_queue.sv
// Circular request queue that feeds a memory port one entry at a time.
// Each entry completes on mem_ack (done) or is discarded after a bounded wait (err).
module mem_access_queue #(
  parameter int data_width = 128,
  parameter int depth      = 4,
  parameter int timeout    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      active,
  input  logic [data_width-1:0]     data_IN,
  output logic                      ready,
  output logic                      mem_req,
  output logic [data_width-1:0]     mem_data,
  input  logic                      mem_ack,
  output logic                      done,
  output logic                      err,
  output logic [7:0]                drops,
  output logic [$clog2(depth):0]    count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int tw = $clog2(timeout + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state;
  logic [data_width-1:0]   mem [depth];
  logic [aw-1:0]           wr_ptr;
  logic [aw-1:0]           rd_ptr;
  logic [tw-1:0]           tcnt;
  logic [cw-1:0]           count_next;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    expired;

  // Push eligibility uses the pre-edge full flag, so a same-edge pop never admits a push.
  always_comb begin
    full       = (count == cw'(depth));
    push       = active & ~full;
    expired    = (tcnt == tw'(timeout - 1));
    pop        = (state == BUSY) & (mem_ack | expired);
    count_next = count;
    if (push && !pop) begin
      count_next = count + cw'(1);
    end else if (pop && !push) begin
      count_next = count - cw'(1);
    end else begin
      count_next = count;
    end
  end

  assign ready    = ~full;
  assign mem_req  = (state == BUSY);
  assign mem_data = mem[rd_ptr];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_IN;
    end
  end

  // Pointers, occupancy, drop counter and the service FSM; ack wins over timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drops  <= 8'd0;
      tcnt   <= '0;
      state  <= IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      count <= count_next;
      if (active && full && drops != 8'd255) drops <= drops + 8'd1;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (count != cw'(0)) state <= BUSY;
        end
        BUSY: begin
          if (mem_ack) begin
            done  <= 1'b1;
            tcnt  <= '0;
            state <= (count_next != cw'(0)) ? BUSY : IDLE;
          end else if (expired) begin
            err   <= 1'b1;
            tcnt  <= '0;
            state <= (count_next != cw'(0)) ? BUSY : IDLE;
          end else begin
            tcnt <= tcnt + tw'(1);
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule
